// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared constants for the generic pipeline-stage register.
//   - OCC_EMPTY / OCC_ONE / OCC_FULL : encodings of the 2-bit occupancy output.
//   - FLUSH_INC_W                    : width of the per-cycle flush increment.
//   - flush_cnt_max()                : saturation point of a w-bit flush counter.
//   Stage-specific ctrl/data field offsets live in the per-stage packages.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // At most main + skid + the incoming entry die in one flush (3), so 2 bits.
  localparam int FLUSH_INC_W = 2;

  // Saturation constant of a w-bit counter: 2**w - 1 (valid for w < 64).
  function automatic longint unsigned flush_cnt_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
//   One storage slot of the pipeline-stage register: valid bit plus control
//   and data bundles. load has priority over clear; clear only drops valid so
//   the data bundle keeps its last value.
//   Ports:
//     clk, rst          rising-edge clock, synchronous active-high reset
//     load              capture ld_ctrl/ld_data and mark the slot valid
//     clear             mark the slot invalid (ignored when load is set)
//     ld_ctrl, ld_data  bundle to capture
//     valid, ctrl, data registered slot contents
// -----------------------------------------------------------------------------
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 20,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; that is what keeps latches from being inferred.
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      ctrl_d  = ld_ctrl;
      data_d  = ld_data;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the wide data bundle is reset too, because out_data must read 0
    // after reset; a plain storage array would normally be left unreset.
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments in sequential blocks so every flop
      // samples pre-edge values regardless of statement order.
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline-stage register with valid/ready handshake, optional
//   two-entry skid buffer, bubble (refuse upstream) and flush (squash all)
//   controls, and a saturating count of squashed valid entries.
//   Configuration macro: PIPE_SKID_EN
//     defined   : main + skid slot, in_ready independent of out_ready.
//     undefined : main slot only, in_ready = (!out_valid || out_ready) && !bubble.
//   Ports:
//     clk, rst              rising-edge clock, synchronous active-high reset
//     in_valid/in_ready     upstream handshake; in_ctrl/in_data upstream bundles
//     out_valid/out_ready   downstream handshake; out_ctrl (0 when !out_valid),
//                           out_data (holds last value when !out_valid)
//     bubble                refuse upstream this cycle; held entries still drain
//     flush                 kill held entries and this cycle's input
//     occ                   entries held (0..2)
//     flush_cnt             saturating count of valid entries killed by flush
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 20,
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              bubble,
  input  logic              flush,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(flush_cnt_max(CNT_W));

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              main_load, main_clear;
  logic [CTRL_W-1:0] main_ld_ctrl;
  logic [DATA_W-1:0] main_ld_data;

  logic accept;
  logic pop;
  logic in_take;    // upstream offered and we were ready, ignoring flush
  logic main_kill;  // main holds an entry that flush destroys (not popped)
  logic skid_kill;

  assign pop     = main_valid && out_ready;
  assign in_take = in_valid && in_ready;
  assign accept  = in_take && !flush;

  // A head popped in the flush cycle reached downstream, so it is not a kill.
  assign main_kill = main_valid && !out_ready;

`ifdef PIPE_SKID_EN

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load, skid_clear;
  logic              main_from_skid;

  // Ready only looks at local state, so there is no path from out_ready.
  assign in_ready  = !skid_valid && !bubble;
  assign skid_kill = skid_valid;

  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (pop && skid_valid) begin
      // Skid refills the head. in_ready is low whenever skid is valid, so no
      // accept can coincide with this move.
      main_load      = 1'b1;
      main_from_skid = 1'b1;
      skid_clear     = 1'b1;
    end else if (accept) begin
      if (!main_valid || pop) main_load = 1'b1;
      else                    skid_load = 1'b1;
    end else if (pop) begin
      main_clear = 1'b1;
    end
  end

  assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_ld_data = main_from_skid ? skid_data : in_data;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .ld_ctrl (in_ctrl),
    .ld_data (in_data),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );

  assign occ = skid_valid ? OCC_FULL : (main_valid ? OCC_ONE : OCC_EMPTY);

`else

  // Single slot: a full stage can only accept when the head leaves this cycle.
  assign in_ready  = (!main_valid || out_ready) && !bubble;
  assign skid_kill = 1'b0;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    if (flush)       main_clear = 1'b1;
    else if (accept) main_load  = 1'b1;
    else if (pop)    main_clear = 1'b1;
  end

  assign main_ld_ctrl = in_ctrl;
  assign main_ld_data = in_data;

  assign occ = main_valid ? OCC_ONE : OCC_EMPTY;

`endif

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .clear   (main_clear),
    .ld_ctrl (main_ld_ctrl),
    .ld_data (main_ld_data),
    .valid   (main_valid),
    .ctrl    (main_ctrl),
    .data    (main_data)
  );

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  // ---------------------------------------------------------------------------
  // Saturating flush counter
  // ---------------------------------------------------------------------------
  logic [FLUSH_INC_W-1:0] flush_inc;
  logic [CNT_W+1:0]       cnt_sum;   // two spare bits so +3 never wraps
  logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;

  always_comb begin
    flush_inc   = '0;
    if (flush) begin
      flush_inc = FLUSH_INC_W'({1'b0, main_kill}) + FLUSH_INC_W'({1'b0, skid_kill})
                + FLUSH_INC_W'({1'b0, in_take});
    end
    cnt_sum     = {2'b00, flush_cnt_q} + (CNT_W+2)'(flush_inc);
    flush_cnt_d = (cnt_sum > {2'b00, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) flush_cnt_q <= '0;
    else     flush_cnt_q <= flush_cnt_d;
  end

  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed scenarios plus randomized traffic against a queue-based reference
//   model of the stage. A second instance with a 2-bit flush counter shares
//   all inputs to exercise saturation. Honours PIPE_SKID_EN like the design.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int CTRL_W = 20;
  localparam int DATA_W = 256;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 2;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              rst, in_valid, out_ready, bubble, flush;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;

  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  flush_cnt;

  logic              s_in_ready, s_out_valid;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [DATA_W-1:0] s_out_data;
  logic [1:0]        s_occ;
  logic [SAT_W-1:0]  s_flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .bubble(bubble), .flush(flush), .occ(occ), .flush_cnt(flush_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .bubble(bubble), .flush(flush), .occ(s_occ), .flush_cnt(s_flush_cnt)
  );

  // ---------------------------------------------------------------------------
  // Reference model: FIFO of held entries, last head data, total kills
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mq[$];
  logic [DATA_W-1:0] m_data = '0;
  int unsigned       m_total = 0;

  int tests = 0;
  int fails = 0;

  function automatic logic m_in_ready();
`ifdef PIPE_SKID_EN
    return (mq.size() < 2) && !bubble;
`else
    return (mq.size() == 0 || out_ready) && !bubble;
`endif
  endfunction

  function automatic logic [CTRL_W-1:0] m_out_ctrl();
    return (mq.size() != 0) ? mq[0].ctrl : '0;
  endfunction

  function automatic logic [CNT_W-1:0] m_cnt();
    return (m_total > 32'(2**CNT_W - 1)) ? '1 : CNT_W'(m_total);
  endfunction

  function automatic logic [SAT_W-1:0] m_cnt_sat();
    return (m_total > 32'(2**SAT_W - 1)) ? '1 : SAT_W'(m_total);
  endfunction

  task automatic model_edge();
    logic   rdy, pop;
    int     n;
    entry_t e;
    if (rst) begin
      mq.delete();
      m_total = 0;
      m_data  = '0;
      return;
    end
    rdy = m_in_ready();
    pop = (mq.size() != 0) && out_ready;
    if (flush) begin
      n = mq.size() + ((in_valid && rdy) ? 1 : 0) - (pop ? 1 : 0);
      m_total += n;
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (in_valid && rdy) begin
        e.ctrl = in_ctrl;
        e.data = in_data;
        mq.push_back(e);
      end
    end
    if (mq.size() != 0) m_data = mq[0].data;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive(input logic iv, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic bub, input logic fl);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = rand_data();
    out_ready = ordy;
    bubble    = bub;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 20'h5, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tests += 6;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    if (out_ctrl !== '0) begin fails++; $display("FAIL reset out_ctrl: got %h want 0", out_ctrl); end
    if (out_data !== '0) begin fails++; $display("FAIL reset out_data: got %h want 0", out_data); end
    if (occ !== 2'd0) begin fails++; $display("FAIL reset occ: got %0d want 0", occ); end
    if (flush_cnt !== '0) begin fails++; $display("FAIL reset flush_cnt: got %0d want 0", flush_cnt); end
    if (s_flush_cnt !== '0) begin fails++; $display("FAIL reset sat flush_cnt: got %0d want 0", s_flush_cnt); end
    rst = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset in_ready bubble: got %b want 0", in_ready); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, CTRL_W'(i), 1'b1, 1'b0, 1'b0);
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL stream in_ready %0d: got %b want 1", i, in_ready); end
      tick();
      tests += 4;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL stream out_valid %0d: got %b want 1", i, out_valid); end
      if (out_ctrl !== CTRL_W'(i)) begin fails++; $display("FAIL stream out_ctrl: got %0d want %0d", out_ctrl, i); end
      if (occ !== 2'd1) begin fails++; $display("FAIL stream occ %0d: got %0d want 1", i, occ); end
      if (out_data !== m_data) begin fails++; $display("FAIL stream out_data %0d: got %h want %h", i, out_data, m_data); end
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    tests += 2;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL stream drain out_valid: got %b want 0", out_valid); end
    if (out_ctrl !== '0) begin fails++; $display("FAIL stream drain out_ctrl: got %h want 0", out_ctrl); end
  endtask

  task automatic test_skid();
    drive(1'b1, 20'hA, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 20'hB, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tests += 3;
    if (occ !== 2'(CAP)) begin fails++; $display("FAIL skid occ: got %0d want %0d", occ, CAP); end
    if (in_ready !== 1'b0) begin fails++; $display("FAIL skid in_ready: got %b want 0", in_ready); end
    if (out_ctrl !== 20'hA) begin fails++; $display("FAIL skid head: got %h want a", out_ctrl); end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    tests += 3;
    if (out_ctrl !== m_out_ctrl()) begin fails++; $display("FAIL skid second: got %h want %h", out_ctrl, m_out_ctrl()); end
    if (in_ready !== m_in_ready()) begin fails++; $display("FAIL skid release in_ready: got %b want %b", in_ready, m_in_ready()); end
    if (occ !== 2'(mq.size())) begin fails++; $display("FAIL skid release occ: got %0d want %0d", occ, mq.size()); end
    tick();
    tests += 2;
    if (occ !== 2'd0) begin fails++; $display("FAIL skid drained occ: got %0d want 0", occ); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL skid drained in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 20'h21, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 20'h22, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 20'h23, 1'b1, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tests += 5;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
    if (out_ctrl !== '0) begin fails++; $display("FAIL midrst out_ctrl: got %h want 0", out_ctrl); end
    if (out_data !== '0) begin fails++; $display("FAIL midrst out_data: got %h want 0", out_data); end
    if (occ !== 2'd0) begin fails++; $display("FAIL midrst occ: got %0d want 0", occ); end
    if (flush_cnt !== '0) begin fails++; $display("FAIL midrst flush_cnt: got %0d want 0", flush_cnt); end
  endtask

  task automatic test_bubble();
    logic [DATA_W-1:0] held;
    drive(1'b1, 20'h11, 1'b1, 1'b0, 1'b0);
    held = in_data;
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, CTRL_W'(32'h12 + k), 1'b1, 1'b1, 1'b0);
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL bubble in_ready %0d: got %b want 0", k, in_ready); end
      tick();
      tests += 3;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL bubble out_valid %0d: got %b want 0", k, out_valid); end
      if (out_ctrl !== '0) begin fails++; $display("FAIL bubble out_ctrl %0d: got %h want 0", k, out_ctrl); end
      if (out_data !== held) begin fails++; $display("FAIL bubble out_data %0d: got %h want %h", k, out_data, held); end
    end
    drive(1'b1, 20'h20, 1'b1, 1'b0, 1'b0);
    tick();
    tests += 2;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL bubble resume valid: got %b want 1", out_valid); end
    if (out_ctrl !== 20'h20) begin fails++; $display("FAIL bubble resume ctrl: got %h want 20", out_ctrl); end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    // Full stage, flush with an offered input that cannot be accepted.
    drive(1'b1, 20'h31, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 20'h32, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 20'h33, 1'b0, 1'b0, 1'b1);
    tick();
    tests += 3;
    if (occ !== 2'd0) begin fails++; $display("FAIL flush full occ: got %0d want 0", occ); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL flush full out_valid: got %b want 0", out_valid); end
    if (flush_cnt !== CNT_W'(CAP)) begin fails++; $display("FAIL flush full cnt: got %0d want %0d", flush_cnt, CAP); end
    // One held entry, flush with an input the stage would take (skid only).
    drive(1'b1, 20'h34, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 20'h35, 1'b0, 1'b0, 1'b1);
    tick();
    tests += 2;
    if (flush_cnt !== CNT_W'(CAP + CAP)) begin fails++; $display("FAIL flush one cnt: got %0d want %0d", flush_cnt, CAP + CAP); end
    if (occ !== 2'd0) begin fails++; $display("FAIL flush one occ: got %0d want 0", occ); end
    // flush together with bubble: bubble masks the input, flush still kills main.
    drive(1'b1, 20'h36, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 20'h37, 1'b0, 1'b1, 1'b1);
    tick();
    tests += 2;
    if (flush_cnt !== CNT_W'(2 * CAP + 1)) begin fails++; $display("FAIL flush bubble cnt: got %0d want %0d", flush_cnt, 2 * CAP + 1); end
    if (occ !== 2'd0) begin fails++; $display("FAIL flush bubble occ: got %0d want 0", occ); end
    // Head popped in the flush cycle is not counted.
    drive(1'b1, 20'h38, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    tick();
    tests += 2;
    if (flush_cnt !== m_cnt()) begin fails++; $display("FAIL flush pop cnt: got %0d want %0d", flush_cnt, m_cnt()); end
    if (s_flush_cnt !== m_cnt_sat()) begin fails++; $display("FAIL flush pop sat cnt: got %0d want %0d", s_flush_cnt, m_cnt_sat()); end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, CTRL_W'(32'h40 + k), 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      tests += 2;
      if (flush_cnt !== CNT_W'(k)) begin fails++; $display("FAIL sat wide cnt %0d: got %0d want %0d", k, flush_cnt, k); end
      if (s_flush_cnt !== SAT_W'((k > 3) ? 3 : k)) begin
        fails++; $display("FAIL sat narrow cnt %0d: got %0d want %0d", k, s_flush_cnt, (k > 3) ? 3 : k);
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 249) == 0);
      drive($urandom_range(0, 3) != 0, CTRL_W'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      tests += 8;
      if (in_ready !== m_in_ready()) begin fails++; $display("FAIL rand in_ready c%0d: got %b want %b", cyc, in_ready, m_in_ready()); end
      if (out_valid !== (mq.size() != 0)) begin fails++; $display("FAIL rand out_valid c%0d: got %b want %b", cyc, out_valid, mq.size() != 0); end
      if (out_ctrl !== m_out_ctrl()) begin fails++; $display("FAIL rand out_ctrl c%0d: got %h want %h", cyc, out_ctrl, m_out_ctrl()); end
      if (out_data !== m_data) begin fails++; $display("FAIL rand out_data c%0d: got %h want %h", cyc, out_data, m_data); end
      if (occ !== 2'(mq.size())) begin fails++; $display("FAIL rand occ c%0d: got %0d want %0d", cyc, occ, mq.size()); end
      if (occ > 2'(CAP)) begin fails++; $display("FAIL rand occ bound c%0d: got %0d want <= %0d", cyc, occ, CAP); end
      if (flush_cnt !== m_cnt()) begin fails++; $display("FAIL rand flush_cnt c%0d: got %0d want %0d", cyc, flush_cnt, m_cnt()); end
      if (s_flush_cnt !== m_cnt_sat()) begin fails++; $display("FAIL rand sat cnt c%0d: got %0d want %0d", cyc, s_flush_cnt, m_cnt_sat()); end
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_skid();
    test_mid_reset();
    test_bubble();
    test_flush();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
